// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Must match the sign-extension unit's format select.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Unknown opcodes and unsupported funct3 values both report as illegal.
    function automatic logic insn_legal(input logic [6:0] op, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LOAD, OP_STORE:  ok = (funct3 == 3'b010);
            OP_BRANCH:          ok = (funct3 == 3'b000) || (funct3 == 3'b001);
            OP_RTYPE, OP_ITYPE: ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                                     (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_JAL:             ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to an ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type: addi has no sub form.
                    3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving datapath muxes, enables and ALU op.
// Latency: lw 5, sw/R/I/jal 4, branch 3 cycles with memory always ready.
// Backpressure: mem_ready low holds FETCH, MEMREAD and MEMWRITE.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       reg_write,
    output logic       illegal
);

    state_t     state, next_state;
    logic [1:0] alu_op;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .op5      (op[5]),
        .alu_ctrl (alu_ctrl)
    );

    always_comb begin
        next_state    = state;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = ADR_PC;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        alu_op        = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute oldPC+imm; jal needs the J immediate, branches the B one.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                if (!insn_legal(op, funct3)) next_state = S_TRAP;
                else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_RTYPE:          next_state = S_EXECR;
                        OP_ITYPE:          next_state = S_EXECI;
                        OP_BRANCH:         next_state = S_BRANCH;
                        default:           next_state = S_JAL;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = op[5] ? IMM_S : IMM_I;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = ADR_ALUOUT;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = ADR_ALUOUT;
                mem_write_raw = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_I;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                result_src   = RES_ALUOUT;
                pc_write_raw = zero ^ funct3[0];
                next_state   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target from ALUOut while ALU forms oldPC+4 for rd.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
                next_state   = S_ALUWB;
            end
            S_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: next_state = S_TRAP;
        endcase
    end

    assign pc_write  = pc_write_raw  & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign illegal   = illegal_raw   & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control words
// are queued by the stimulus and checked by an independent monitor.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;

    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q[$];
    string       name_q[$];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_ctrl(alu_ctrl), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Field order: pc_write adr_src mem_write ir_write result_src a b imm alu reg_write illegal
    function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic rw, input logic ill);
        return {pcw, adr, mw, irw, res, a, b, imm, alu, rw, ill};
    endfunction

    wire [16:0] act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                       alu_src_b, imm_src, alu_ctrl, reg_write, illegal};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %b, expected %b", n, act, e);
            end
        end
    end

    task automatic step(input logic rst, input logic mr, input logic z,
                        input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [16:0] e, input string n);
        @(posedge clk);
        #1;
        rst_n = rst; mem_ready = mr; zero = z; op = o; funct3 = f3; funct7b5 = f7;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Hand-written per-state control words
    localparam logic [16:0] E_FETCH    = 17'b1_0_0_1_10_00_10_00_000_0_0;
    localparam logic [16:0] E_FETCH_W  = 17'b0_0_0_0_10_00_10_00_000_0_0;
    localparam logic [16:0] E_DEC_B    = 17'b0_0_0_0_00_01_01_10_000_0_0;
    localparam logic [16:0] E_DEC_J    = 17'b0_0_0_0_00_01_01_11_000_0_0;
    localparam logic [16:0] E_MADR_LW  = 17'b0_0_0_0_00_10_01_00_000_0_0;
    localparam logic [16:0] E_MADR_SW  = 17'b0_0_0_0_00_10_01_01_000_0_0;
    localparam logic [16:0] E_MREAD    = 17'b0_1_0_0_00_00_00_00_000_0_0;
    localparam logic [16:0] E_MWB      = 17'b0_0_0_0_01_00_00_00_000_1_0;
    localparam logic [16:0] E_MWRITE   = 17'b0_1_1_0_00_00_00_00_000_0_0;
    localparam logic [16:0] E_ALUWB    = 17'b0_0_0_0_00_00_00_00_000_1_0;
    localparam logic [16:0] E_JAL      = 17'b1_0_0_0_00_01_10_00_000_0_0;
    localparam logic [16:0] E_TRAP     = 17'b0_0_0_0_00_00_00_00_000_0_1;
    localparam logic [16:0] E_ZERO     = 17'b0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           LUI = 7'b0110111;

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;

        // Reset holds FETCH with enables forced low even though memory is ready
        step(0, 1, 0, LW, 3'b010, 0, E_FETCH_W, "reset_fetch");

        // lw, memory always ready
        step(1, 1, 0, LW, 3'b010, 0, E_FETCH,   "lw_fetch");
        step(1, 1, 0, LW, 3'b010, 0, E_DEC_B,   "lw_decode");
        step(1, 1, 0, LW, 3'b010, 0, E_MADR_LW, "lw_memadr");
        step(1, 1, 0, LW, 3'b010, 0, E_MREAD,   "lw_memread");
        step(1, 1, 0, LW, 3'b010, 0, E_MWB,     "lw_memwb");

        // sw with a fetch stall and two write stalls
        step(1, 0, 0, SW, 3'b010, 0, E_FETCH_W, "sw_fetch_wait");
        step(1, 1, 0, SW, 3'b010, 0, E_FETCH,   "sw_fetch");
        step(1, 1, 0, SW, 3'b010, 0, E_DEC_B,   "sw_decode");
        step(1, 1, 0, SW, 3'b010, 0, E_MADR_SW, "sw_memadr");
        step(1, 0, 0, SW, 3'b010, 0, E_MWRITE,  "sw_write_w1");
        step(1, 0, 0, SW, 3'b010, 0, E_MWRITE,  "sw_write_w2");
        step(1, 1, 0, SW, 3'b010, 0, E_MWRITE,  "sw_write_done");

        // R-type sub
        step(1, 1, 0, RT, 3'b000, 1, E_FETCH, "sub_fetch");
        step(1, 1, 0, RT, 3'b000, 1, E_DEC_B, "sub_decode");
        step(1, 1, 0, RT, 3'b000, 1, ov(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "sub_execr");
        step(1, 1, 0, RT, 3'b000, 1, E_ALUWB, "sub_aluwb");

        // addi with the same funct bits stays add
        step(1, 1, 0, IT, 3'b000, 1, E_FETCH, "addi_fetch");
        step(1, 1, 0, IT, 3'b000, 1, E_DEC_B, "addi_decode");
        step(1, 1, 0, IT, 3'b000, 1, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0), "addi_execi");
        step(1, 1, 0, IT, 3'b000, 1, E_ALUWB, "addi_aluwb");

        // ori, slt, and
        step(1, 1, 0, IT, 3'b110, 0, E_FETCH, "ori_fetch");
        step(1, 1, 0, IT, 3'b110, 0, E_DEC_B, "ori_decode");
        step(1, 1, 0, IT, 3'b110, 0, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0,0), "ori_execi");
        step(1, 1, 0, IT, 3'b110, 0, E_ALUWB, "ori_aluwb");
        step(1, 1, 0, RT, 3'b010, 0, E_FETCH, "slt_fetch");
        step(1, 1, 0, RT, 3'b010, 0, E_DEC_B, "slt_decode");
        step(1, 1, 0, RT, 3'b010, 0, ov(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0), "slt_execr");
        step(1, 1, 0, RT, 3'b010, 0, E_ALUWB, "slt_aluwb");
        step(1, 1, 0, RT, 3'b111, 0, E_FETCH, "and_fetch");
        step(1, 1, 0, RT, 3'b111, 0, E_DEC_B, "and_decode");
        step(1, 1, 0, RT, 3'b111, 0, ov(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,0), "and_execr");
        step(1, 1, 0, RT, 3'b111, 0, E_ALUWB, "and_aluwb");

        // beq taken, bne not taken, bne taken
        step(1, 1, 1, BR, 3'b000, 0, E_FETCH, "beq_fetch");
        step(1, 1, 1, BR, 3'b000, 0, E_DEC_B, "beq_decode");
        step(1, 1, 1, BR, 3'b000, 0, ov(1,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "beq_z1");
        step(1, 1, 1, BR, 3'b001, 0, E_FETCH, "bne_fetch");
        step(1, 1, 1, BR, 3'b001, 0, E_DEC_B, "bne_decode");
        step(1, 1, 1, BR, 3'b001, 0, ov(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "bne_z1");
        step(1, 1, 0, BR, 3'b001, 0, E_FETCH, "bne2_fetch");
        step(1, 1, 0, BR, 3'b001, 0, E_DEC_B, "bne2_decode");
        step(1, 1, 0, BR, 3'b001, 0, ov(1,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "bne_z0");

        // jal
        step(1, 1, 0, JL, 3'b000, 0, E_FETCH, "jal_fetch");
        step(1, 1, 0, JL, 3'b000, 0, E_DEC_J, "jal_decode");
        step(1, 1, 0, JL, 3'b000, 0, E_JAL,   "jal_jal");
        step(1, 1, 0, JL, 3'b000, 0, E_ALUWB, "jal_aluwb");

        // Reset during lw MEMREAD: no writeback follows
        step(1, 1, 0, LW, 3'b010, 0, E_FETCH,   "lwr_fetch");
        step(1, 1, 0, LW, 3'b010, 0, E_DEC_B,   "lwr_decode");
        step(1, 1, 0, LW, 3'b010, 0, E_MADR_LW, "lwr_memadr");
        step(0, 1, 0, LW, 3'b010, 0, E_MREAD,   "lwr_memread_rst");
        step(0, 1, 0, LW, 3'b010, 0, E_FETCH_W, "lwr_after_rst");
        step(1, 1, 0, LW, 3'b010, 0, E_FETCH,   "lwr_release");

        // lui traps and stays until reset
        step(1, 1, 0, LUI, 3'b000, 0, E_DEC_B, "lui_decode");
        step(1, 1, 0, LUI, 3'b000, 0, E_TRAP,  "lui_trap1");
        step(1, 1, 0, LUI, 3'b000, 0, E_TRAP,  "lui_trap2");
        step(1, 1, 0, RT,  3'b000, 0, E_TRAP,  "lui_trap3");
        step(0, 1, 0, RT,  3'b000, 0, E_ZERO,  "trap_rst");
        step(1, 1, 0, LW,  3'b000, 0, E_FETCH, "bad_lw_fetch");

        // lw with invalid funct3 traps
        step(1, 1, 0, LW, 3'b000, 0, E_DEC_B, "bad_lw_decode");
        step(1, 1, 0, LW, 3'b000, 0, E_TRAP,  "bad_lw_trap");
        step(0, 1, 0, LW, 3'b000, 0, E_ZERO,  "bad_lw_rst");
        step(1, 1, 0, LW, 3'b010, 0, E_FETCH, "final_fetch");

        begin : drain
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                failures++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
